// File: rtl/nv_ram_rws_param.sv
// nv_ram_rws_param: single-port-read / single-port-write RAM with per-lane
// write mask, optional output register, write-through bypass on address
// collision and an optional zero-fill sequence after reset.
module nv_ram_rws_param #(
  parameter int DEPTH         = 64,
  parameter int WIDTH         = 1024,
  parameter int MASK_GRAN     = 8,
  parameter int OUT_REG       = 0,
  parameter int BYPASS        = 1,
  parameter int INIT_ON_RESET = 1,
  localparam int AW = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
  localparam int MW = WIDTH / MASK_GRAN
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic [AW-1:0]    ra,
  input  logic             re,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic [AW-1:0]    wa,
  input  logic             we,
  input  logic [MW-1:0]    wmask,
  input  logic [WIDTH-1:0] di,
  output logic             init_busy,
  input  logic [31:0]      pwrbus_ram_pd
);

  // DEPTH widened by one bit so address range checks never truncate
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_INIT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             fill_s;
  logic             idle_s;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we_s;
  logic [AW-1:0]    mem_wa_s;
  logic [MW-1:0]    mem_wmask_s;
  logic [WIDTH-1:0] mem_wd_s;

  logic             rd_acc_s;
  logic             rd_in_range_s;
  logic             wr_in_range_s;
  logic             byp_hit_s;
  logic [WIDTH-1:0] rd_raw_s;
  logic [WIDTH-1:0] rd_merge_s;

  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_vld_q, rd_vld_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;

  // power-down bus is carried for integration only
  logic             unused_pwrbus_s;
  assign unused_pwrbus_s = ^pwrbus_ram_pd;

  // FSM state and fill counter registers; reset restarts the fill from entry 0
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state logic: fill counter stops at the last entry, IDLE is terminal
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q;
        end else begin
          state_d = ST_INIT;
          cnt_d   = cnt_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM outputs: fill active and user traffic enable
  always_comb begin
    fill_s = 1'b0;
    idle_s = 1'b0;
    case (state_q)
      ST_INIT: fill_s = 1'b1;
      ST_IDLE: idle_s = 1'b1;
      default: begin
        fill_s = 1'b0;
        idle_s = 1'b0;
      end
    endcase
  end

  assign init_busy = fill_s;

  // write port select: zero-fill during INIT, otherwise masked user write
  always_comb begin
    wr_in_range_s = ({1'b0, wa} < DEPTH_W);
    mem_we_s      = 1'b0;
    mem_wa_s      = '0;
    mem_wmask_s   = '0;
    mem_wd_s      = '0;
    if (!nvdla_core_rstn) begin
      mem_we_s = 1'b0;
    end else if (fill_s) begin
      mem_we_s    = 1'b1;
      mem_wa_s    = cnt_q;
      mem_wmask_s = '1;
      mem_wd_s    = '0;
    end else if (idle_s && we && wr_in_range_s) begin
      mem_we_s    = 1'b1;
      mem_wa_s    = wa;
      mem_wmask_s = wmask;
      mem_wd_s    = di;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // storage array: per-lane write, no reset so contents survive rstn
  always_ff @(posedge nvdla_core_clk) begin
    for (int i = 0; i < MW; i++) begin
      if (mem_we_s && mem_wmask_s[i]) begin
        mem_q[mem_wa_s][i*MASK_GRAN +: MASK_GRAN] <= mem_wd_s[i*MASK_GRAN +: MASK_GRAN];
      end
    end
  end

  // read capture: out-of-range reads return zero, masked lanes bypass on collision
  always_comb begin
    rd_acc_s      = re && idle_s;
    rd_in_range_s = ({1'b0, ra} < DEPTH_W);
    byp_hit_s     = (BYPASS != 0) && we && idle_s && (wa == ra) && rd_in_range_s;
    if (rd_in_range_s) begin
      rd_raw_s = mem_q[ra];
    end else begin
      rd_raw_s = '0;
    end
    rd_merge_s = rd_raw_s;
    for (int i = 0; i < MW; i++) begin
      if (byp_hit_s && wmask[i]) begin
        rd_merge_s[i*MASK_GRAN +: MASK_GRAN] = di[i*MASK_GRAN +: MASK_GRAN];
      end else begin
        rd_merge_s[i*MASK_GRAN +: MASK_GRAN] = rd_raw_s[i*MASK_GRAN +: MASK_GRAN];
      end
    end
    if (rd_acc_s) begin
      rd_data_d = rd_merge_s;
    end else begin
      rd_data_d = rd_data_q;
    end
    rd_vld_d = rd_acc_s;
  end

  // optional second stage: only advances on a valid first-stage result
  always_comb begin
    if (rd_vld_q) begin
      dout_d = rd_data_q;
    end else begin
      dout_d = dout_q;
    end
    dout_vld_d = rd_vld_q;
  end

  // read pipeline registers; reset drops any read in flight
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      rd_data_q  <= '0;
      rd_vld_q   <= 1'b0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_vld_q   <= rd_vld_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign dout     = (OUT_REG != 0) ? dout_q     : rd_data_q;
  assign dout_vld = (OUT_REG != 0) ? dout_vld_q : rd_vld_q;

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Bench for nv_ram_rws_param: two instances (64 entries / latency 1 / bypass,
// and 48 entries / latency 2 / no bypass) driven with identical stimulus and
// checked against a behavioural memory model plus expected-read queues.
module tb_nv_ram_rws_param;

  localparam int W  = 1024;
  localparam int MW = 128;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic          re, we;
  logic [AW-1:0] ra, wa;
  logic [MW-1:0] wmask;
  logic [W-1:0]  di;
  logic [31:0]   pwr;

  logic [W-1:0]  a_dout, b_dout;
  logic          a_vld, b_vld, a_busy, b_busy;

  always #5 clk = ~clk;

  nv_ram_rws_param #(.DEPTH(64), .WIDTH(1024), .MASK_GRAN(8), .OUT_REG(0),
                     .BYPASS(1), .INIT_ON_RESET(1)) u_a (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .ra(ra), .re(re), .dout(a_dout), .dout_vld(a_vld),
    .wa(wa), .we(we), .wmask(wmask), .di(di),
    .init_busy(a_busy), .pwrbus_ram_pd(pwr));

  nv_ram_rws_param #(.DEPTH(48), .WIDTH(1024), .MASK_GRAN(8), .OUT_REG(1),
                     .BYPASS(0), .INIT_ON_RESET(1)) u_b (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .ra(ra), .re(re), .dout(b_dout), .dout_vld(b_vld),
    .wa(wa), .we(we), .wmask(wmask), .di(di),
    .init_busy(b_busy), .pwrbus_ram_pd(pwr));

  typedef struct {
    int         due;
    logic [W-1:0] data;
  } exp_t;

  exp_t          sb_a[$];
  exp_t          sb_b[$];
  logic [W-1:0]  mdl [2][64];
  int            depth_c [2] = '{64, 48};
  int            outreg_c[2] = '{0, 1};
  int            byp_c   [2] = '{1, 0};
  int            busy_cnt[2] = '{0, 0};
  logic [W-1:0]  held    [2];
  int            cyc_n = 0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got[127:0]=%h exp[127:0]=%h", tag, cyc_n, got[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [W-1:0] merge_lanes(input logic [W-1:0] old_v, input logic [W-1:0] new_v,
                                               input logic [MW-1:0] m);
    logic [W-1:0] r;
    r = old_v;
    for (int l = 0; l < MW; l++) begin
      if (m[l]) r[l*8 +: 8] = new_v[l*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pat(input logic [7:0] b);
    return {128{b}};
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int j = 0; j < 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_m();
    logic [MW-1:0] r;
    for (int j = 0; j < 4; j++) r[j*32 +: 32] = $urandom;
    if ($urandom_range(0, 5) == 0) r = '0;
    return r;
  endfunction

  // model update for the edge just taken, using the inputs it sampled
  task automatic model_edge(input int i);
    exp_t e;
    if (!rstn) begin
      if (i == 0) sb_a.delete(); else sb_b.delete();
      held[i]     = '0;
      busy_cnt[i] = depth_c[i];
    end else if (busy_cnt[i] > 0) begin
      mdl[i][depth_c[i] - busy_cnt[i]] = '0;
      busy_cnt[i]--;
    end else begin
      if (re) begin
        e.data = (int'(ra) < depth_c[i]) ? mdl[i][ra] : '0;
        if (byp_c[i] != 0 && we && wa == ra && int'(ra) < depth_c[i])
          e.data = merge_lanes(e.data, di, wmask);
        e.due = cyc_n + outreg_c[i];
        if (i == 0) sb_a.push_back(e); else sb_b.push_back(e);
      end
      if (we && int'(wa) < depth_c[i])
        mdl[i][wa] = merge_lanes(mdl[i][wa], di, wmask);
    end
  endtask

  task automatic check_inst(input int i);
    exp_t         e;
    bit           hit;
    logic [W-1:0] d;
    logic         v, b;
    string        nm;
    hit = 1'b0;
    if (i == 0) begin
      nm = "A"; d = a_dout; v = a_vld; b = a_busy;
      if (sb_a.size() > 0 && sb_a[0].due == cyc_n) begin e = sb_a.pop_front(); hit = 1'b1; end
    end else begin
      nm = "B"; d = b_dout; v = b_vld; b = b_busy;
      if (sb_b.size() > 0 && sb_b[0].due == cyc_n) begin e = sb_b.pop_front(); hit = 1'b1; end
    end
    check_val({nm, ".init_busy"}, W'(b), W'(busy_cnt[i] > 0));
    check_val({nm, ".dout_vld"}, W'(v), W'(hit));
    if (hit) held[i] = e.data;
    check_val({nm, ".dout"}, d, held[i]);
  endtask

  task automatic step(input logic r_n, input logic r_e, input logic [AW-1:0] r_a,
                      input logic w_e, input logic [AW-1:0] w_a,
                      input logic [MW-1:0] w_m, input logic [W-1:0] d);
    rstn = r_n; re = r_e; ra = r_a; we = w_e; wa = w_a; wmask = w_m; di = d;
    @(posedge clk);
    cyc_n++;
    model_edge(0);
    model_edge(1);
    #1;
    check_inst(0);
    check_inst(1);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic rst_cyc();
    step(1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input int a);
    step(1'b1, 1'b1, AW'(a), 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input int a, input logic [MW-1:0] m, input logic [W-1:0] d);
    step(1'b1, 1'b0, '0, 1'b1, AW'(a), m, d);
  endtask

  initial begin
    logic [MW-1:0] ones_m;
    logic [MW-1:0] lane0_m;
    ones_m  = '1;
    lane0_m = '0;
    lane0_m[0] = 1'b1;
    rstn = 1'b0; re = 1'b0; we = 1'b0; ra = '0; wa = '0; wmask = '0; di = '0;
    pwr  = 32'h0;

    // reset, then init with traffic that must be ignored while busy
    repeat (3) rst_cyc();
    for (int k = 0; k < 64; k++) step(1'b1, 1'b1, AW'(k), 1'b1, AW'(9), ones_m, pat(8'hFF));
    repeat (2) idle();
    for (int k = 0; k < 64; k++) rd(k);
    repeat (2) idle();

    // masked write on entry 5
    wr(5, ones_m, pat(8'hFF));
    wr(5, lane0_m, '0);
    rd(5);
    repeat (3) idle();

    // latency / hold on entry 3, then overwrite must not disturb dout
    wr(3, ones_m, pat(8'hA5));
    rd(3);
    repeat (3) idle();
    wr(3, ones_m, pat(8'h5A));
    repeat (2) idle();

    // collision on entry 7
    wr(7, ones_m, pat(8'h11));
    step(1'b1, 1'b1, AW'(7), 1'b1, AW'(7), lane0_m, pat(8'h22));
    rd(7);
    repeat (3) idle();

    // out-of-range for the 48-entry instance
    wr(50, ones_m, pat(8'hFF));
    rd(50);
    for (int k = 0; k < 48; k++) rd(k);
    repeat (2) idle();

    // mixed random traffic
    for (int k = 0; k < 300; k++)
      step(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), rand_m(), rand_w());
    repeat (2) idle();

    // reset one cycle after a read, then reset again at fill count 20
    rd(3);
    rst_cyc();
    rst_cyc();
    repeat (20) idle();
    rst_cyc();
    repeat (66) idle();
    for (int k = 0; k < 64; k++) rd(k);
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nv_ram_rws_param.md
NV_RAM_RWS_PARAM -- requirements
Module: nv_ram_rws_param

Interface
REQ-001 The block SHALL expose the following parameters (one per line: name, default, meaning):
- DEPTH, 64, number of entries (any value >= 2; not required to be a power of two)
- WIDTH, 1024, data bits per entry
- MASK_GRAN, 8, bits per write-mask lane; WIDTH SHALL be a multiple of MASK_GRAN
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2
- BYPASS, 1, 1 = write-through on a same-cycle same-address collision; 0 = read returns old data
- INIT_ON_RESET, 1, 1 = zero-fill all entries after reset; 0 = no fill

REQ-002 The block SHALL derive AW = max(1, clog2(DEPTH)) and MW = WIDTH/MASK_GRAN.

REQ-003 The block SHALL expose the following ports (one per line: name, direction, width, meaning):
- nvdla_core_clk, input, 1, the only clock
- nvdla_core_rstn, input, 1, reset: synchronous and active-low
- ra, input, AW, read address
- re, input, 1, read enable
- dout, output, WIDTH, registered read data
- dout_vld, output, 1, one-cycle pulse marking new dout
- wa, input, AW, write address
- we, input, 1, write enable
- wmask, input, MW, per-lane write enable; bit i covers di[i*MASK_GRAN +: MASK_GRAN]
- di, input, WIDTH, write data
- init_busy, output, 1, zero-fill in progress
- pwrbus_ram_pd, input, 32, power-down bus; no functional effect

REQ-004 All state SHALL be updated only on the rising edge of nvdla_core_clk.

Function
REQ-005 Write: when we=1, init_busy=0 and wa<DEPTH, each lane of M[wa] with wmask[i]=1 SHALL take di lane i; lanes with wmask[i]=0 SHALL be unchanged.
REQ-006 A write with wa>=DEPTH, or with wmask all zero, SHALL leave memory unchanged.
REQ-007 Read: when re=1 and init_busy=0, the block SHALL capture M[ra].
- With OUT_REG=0, dout SHALL present that data in the next cycle.
- With OUT_REG=1, dout SHALL present it two cycles later.
- dout_vld SHALL be 1 in exactly the cycle the new data first appears on dout.
REQ-008 A read with ra>=DEPTH SHALL return all zeros and SHALL still pulse dout_vld.
REQ-009 dout SHALL hold its last value until the next accepted read updates it; later writes to that address SHALL NOT change dout.
REQ-010 Back-to-back reads (re=1 every cycle) SHALL give one result per cycle, in order, at full throughput.
REQ-011 Collision (re=1 and we=1 in the same cycle with ra==wa<DEPTH):
- With BYPASS=1, masked lanes SHALL return di and unmasked lanes SHALL return the old contents.
- With BYPASS=0, all lanes SHALL return the old contents.
- In both cases the write SHALL complete.
REQ-012 Init FSM states:
- IDLE: normal operation.
- INIT: a counter cnt (AW bits) SHALL write all-zero to M[cnt] each cycle, then increment.
REQ-013 FSM transitions:
- Reset SHALL go to INIT with cnt=0 if INIT_ON_RESET=1, otherwise to IDLE.
- INIT SHALL go to IDLE on the cycle after M[DEPTH-1] is written, so the fill takes exactly DEPTH cycles after reset release.
- IDLE SHALL be terminal until the next reset.
REQ-014 init_busy SHALL be 1 exactly while in INIT.
- re and we SHALL be ignored while init_busy=1, with no memory change and no dout_vld.
- The first cycle with init_busy=0 SHALL accept re and we.
REQ-015 The cnt counter SHALL stop at DEPTH-1 and SHALL NOT wrap during INIT.

Reset
REQ-016 While nvdla_core_rstn=0 at a clock edge, the block SHALL set:
- dout=0, dout_vld=0 and all output pipeline registers to 0;
- the FSM per REQ-013 and cnt=0;
- init_busy=1 if INIT_ON_RESET=1, otherwise 0.
REQ-017 Reset SHALL cancel any in-flight read, with no dout_vld after release for a read accepted before reset.
REQ-018 Reset asserted mid-INIT SHALL restart the fill from entry 0.
REQ-019 Reset SHALL NOT clear memory except through the INIT fill; with INIT_ON_RESET=0, memory contents after reset SHALL be preserved.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Init (DEPTH=64, INIT_ON_RESET=1): release reset -> init_busy=1 for exactly 64 cycles; read of every entry returns 0.
- Masked write (WIDTH=1024, MASK_GRAN=8): write all-ones to entry 5, then write di=0 with wmask=0x...0001 -> read of entry 5 returns all-ones except bits[7:0]=0x00.
- Latency (OUT_REG=1): write 0xA5-pattern to entry 3; re=1 ra=3 at cycle t -> dout_vld=1 and dout=pattern at t+2 only; dout holds afterwards.
- Collision: entry 7 holds 0x11-pattern; same-cycle re/we to 7 with di=0x22-pattern, wmask lane0 only -> BYPASS=1: lane0=0x22, others 0x11; BYPASS=0: all 0x11; a subsequent read returns the merged value.
- Out-of-range (DEPTH=48): we to wa=50 then re ra=50 -> dout=0 with dout_vld=1; entries 0..47 unchanged.
- Reset mid-operation: assert rstn=0 one cycle after re, and again at INIT cnt=20 -> no dout_vld; dout=0; fill restarts and takes 64 cycles.
